// File: rtl/mips32_issue_scheduler.sv
// rtl/mips32_issue_scheduler.sv - ID-to-EX issue controller with RAW scoreboard, branch flush and HLT drain
//
// Purpose:
//   Decides each cycle whether the instruction in ID issues to EX, is held
//   (stall, bubble into EX) or is discarded (flush on a taken branch in EX).
//   In-flight register writes are tracked in a DEPTH-entry shift-register
//   scoreboard (entry 0 = EX, entry DEPTH-1 = WB). A HLT that issues blocks
//   all further issue and raises the sticky halted flag once the pipeline
//   behind it has fully drained.
//
// Build option:
//   MIPS32_FWD_EN - when defined, the datapath forwards EX/MEM/WB results and
//                   only a load in EX that feeds the ID instruction stalls.
//                   When undefined, full interlock over every tracked stage.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active high
//   id_valid     in   ID holds a valid instruction
//   id_rs/id_rt  in   source register numbers
//   id_use_rs/rt in   instruction actually reads the source
//   id_dst       in   destination register number
//   id_wr        in   instruction writes id_dst
//   id_load      in   instruction is LW
//   id_halt      in   instruction is HLT
//   ex_taken     in   branch in EX resolved taken this cycle
//   issue        out  ID instruction advances to EX
//   stall        out  ID instruction held, bubble into EX
//   flush        out  ID/IF contents discarded
//   halted       out  HLT issued and pipeline drained (sticky until reset)
//   stall_count  out  saturating count of stall cycles

module mips32_issue_scheduler #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       id_dst,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             id_halt,
  input  logic             ex_taken,
  output logic             issue,
  output logic             stall,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state, state_next;

  // Scoreboard, one bit-vector per field so the shift is a simple index move.
  logic [DEPTH-1:0] sb_occ;
  logic [DEPTH-1:0] sb_wv;
  logic [DEPTH-1:0] sb_ld;
  logic [4:0]       sb_dst [DEPTH];

  logic             halt_pending;
  logic             sb_empty;
  logic             rs_live;
  logic             rt_live;
  logic             hazard;

  // A source of R0 can never be produced by anyone, so it never matches.
  assign rs_live  = id_use_rs & (id_rs != 5'd0);
  assign rt_live  = id_use_rt & (id_rt != 5'd0);
  assign sb_empty = ~(|sb_occ);

  // Both DRAIN and HALT block issue; HALT only differs by raising halted.
  assign halt_pending = (state != ST_RUN);
  assign halted       = (state == ST_HALT);

  always_comb begin
    hazard = 1'b0;
`ifdef MIPS32_FWD_EN
    // With full forwarding only a load still in EX cannot feed ID in time.
    if (sb_wv[0] && sb_ld[0] &&
        ((rs_live && (sb_dst[0] == id_rs)) || (rt_live && (sb_dst[0] == id_rt))))
      hazard = 1'b1;
`else
    // No bypass anywhere, including register-file write-to-read, so every
    // stage up to and including WB is a hazard source.
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_wv[i] &&
          ((rs_live && (sb_dst[i] == id_rs)) || (rt_live && (sb_dst[i] == id_rt))))
        hazard = 1'b1;
    end
`endif
  end

  // Issue decision and halt sequencing.
  always_comb begin
    state_next = state;
    flush      = ex_taken;
    issue      = 1'b0;
    stall      = 1'b0;

    // Flush dominates: the ID instruction is on the wrong path, so it must
    // neither issue, stall nor (for HLT) start the drain.
    if (id_valid && !halt_pending && !ex_taken) begin
      issue = ~hazard;
      stall = hazard;
    end

    case (state)
      ST_RUN: begin
        if (issue && id_halt)
          state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The HLT itself occupies the scoreboard, so this waits for it to retire.
        if (sb_empty)
          state_next = ST_HALT;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_RUN;
    else
      state <= state_next;
  end

  // Scoreboard shift: entries keep retiring even on a flush, because
  // everything older than the branch in EX is architecturally valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_occ <= '0;
      sb_wv  <= '0;
      sb_ld  <= '0;
      for (int i = 0; i < DEPTH; i++)
        sb_dst[i] <= 5'd0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sb_occ[i] <= sb_occ[i-1];
        sb_wv[i]  <= sb_wv[i-1];
        sb_ld[i]  <= sb_ld[i-1];
        sb_dst[i] <= sb_dst[i-1];
      end
      sb_occ[0] <= issue;
      // Writes to R0 are discarded by the register file, so never track them.
      sb_wv[0]  <= issue & id_wr & (id_dst != 5'd0);
      sb_ld[0]  <= issue & id_load;
      sb_dst[0] <= issue ? id_dst : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (stall && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + CNT_ONE;
  end

endmodule

// File: tb/tb_mips32_issue_scheduler.sv
// tb/tb_mips32_issue_scheduler.sv - directed self-checking bench for mips32_issue_scheduler

module tb_mips32_issue_scheduler;

  localparam int DEPTH = 3;
  localparam int CNT_W = 4;
`ifdef MIPS32_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       id_dst;
  logic             id_wr;
  logic             id_load;
  logic             id_halt;
  logic             ex_taken;
  logic             issue;
  logic             stall;
  logic             flush;
  logic             halted;
  logic [CNT_W-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  mips32_issue_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_dst      (id_dst),
    .id_wr       (id_wr),
    .id_load     (id_load),
    .id_halt     (id_halt),
    .ex_taken    (ex_taken),
    .issue       (issue),
    .stall       (stall),
    .flush       (flush),
    .halted      (halted),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid  = 1'b0;
    id_rs     = 5'd0;
    id_rt     = 5'd0;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    id_dst    = 5'd0;
    id_wr     = 1'b0;
    id_load   = 1'b0;
    id_halt   = 1'b0;
    ex_taken  = 1'b0;
  endtask

  task automatic set_inst(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt,
                          input logic [4:0] dst, input logic wr,
                          input logic ld, input logic hlt);
    id_valid  = 1'b1;
    id_rs     = rs;
    id_rt     = rt;
    id_use_rs = urs;
    id_use_rt = urt;
    id_dst    = dst;
    id_wr     = wr;
    id_load   = ld;
    id_halt   = hlt;
    ex_taken  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
    checks++; if ({issue, stall, flush} !== 3'b000) begin errors++; $display("FAIL reset_outputs got=%b exp=000", {issue, stall, flush}); end
    set_inst(5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if ({issue, stall} !== 2'b10) begin errors++; $display("FAIL reset_empty_sb_issue got=%b exp=10", {issue, stall}); end
    idle();
    tick();
  endtask

  // ADDI R1,R0,10 ; ADD R4,R1,R2
  task automatic test_back_to_back();
    int exp_stalls;
    exp_stalls = FWD ? 0 : DEPTH;
    do_reset();
    set_inst(5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL b2b_addi_issue got=%b exp=1", issue); end
    tick();
    set_inst(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < exp_stalls; c++) begin
      @(negedge clk);
      checks++; if ({issue, stall} !== 2'b01) begin errors++; $display("FAIL b2b_stall_cycle%0d got=%b exp=01", c, {issue, stall}); end
      tick();
    end
    @(negedge clk);
    checks++; if ({issue, stall} !== 2'b10) begin errors++; $display("FAIL b2b_add_issue got=%b exp=10", {issue, stall}); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (stall_count !== 4'(exp_stalls)) begin errors++; $display("FAIL b2b_stall_count got=%0d exp=%0d", stall_count, exp_stalls); end
  endtask

  // LW R2,0(R1) ; ADD R3,R2,R2
  task automatic test_load_use();
    int exp_stalls;
    exp_stalls = FWD ? 1 : DEPTH;
    do_reset();
    set_inst(5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL lu_lw_issue got=%b exp=1", issue); end
    tick();
    set_inst(5'd2, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < exp_stalls; c++) begin
      @(negedge clk);
      checks++; if ({issue, stall} !== 2'b01) begin errors++; $display("FAIL lu_stall_cycle%0d got=%b exp=01", c, {issue, stall}); end
      tick();
    end
    @(negedge clk);
    checks++; if ({issue, stall} !== 2'b10) begin errors++; $display("FAIL lu_add_issue got=%b exp=10", {issue, stall}); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (stall_count !== 4'(exp_stalls)) begin errors++; $display("FAIL lu_stall_count got=%0d exp=%0d", stall_count, exp_stalls); end
  endtask

  // ADDI R0,R0,5 ; ADD R4,R0,R0
  task automatic test_r0();
    do_reset();
    set_inst(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_inst(5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if ({issue, stall} !== 2'b10) begin errors++; $display("FAIL r0_add_issue got=%b exp=10", {issue, stall}); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL r0_stall_count got=%0d exp=0", stall_count); end
  endtask

  task automatic test_halt();
    int exp_stalls;
    exp_stalls = FWD ? 0 : DEPTH;
    do_reset();
    set_inst(5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);       // ADDI R1
    tick();
    set_inst(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);       // ADD R4,R1,R2
    for (int c = 0; c < exp_stalls; c++) tick();
    tick();
    set_inst(5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);       // ADDI R5
    tick();
    set_inst(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);       // HLT
    @(negedge clk);
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL halt_hlt_issue got=%b exp=1", issue); end
    tick();
    set_inst(5'd0, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);       // independent, must not issue
    for (int k = 0; k < DEPTH + 1; k++) begin
      @(negedge clk);
      checks++; if ({issue, stall, halted} !== 3'b000) begin errors++; $display("FAIL halt_drain%0d got=%b exp=000", k, {issue, stall, halted}); end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({issue, halted} !== 2'b01) begin errors++; $display("FAIL halt_sticky%0d got=%b exp=01", k, {issue, halted}); end
      tick();
    end
    checks++; if (stall_count !== 4'(exp_stalls)) begin errors++; $display("FAIL halt_stall_count got=%0d exp=%0d", stall_count, exp_stalls); end
    do_reset();
    @(negedge clk);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_rst_halted got=%b exp=0", halted); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL halt_rst_count got=%0d exp=0", stall_count); end
    set_inst(5'd5, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);       // reads R5, scoreboard must be clear
    @(negedge clk);
    checks++; if ({issue, stall} !== 2'b10) begin errors++; $display("FAIL halt_rst_issue got=%b exp=10", {issue, stall}); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_inst(5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);       // ADDI R1
    tick();
    set_inst(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);       // hazarded ADD
    ex_taken = 1'b1;
    @(negedge clk);
    checks++; if ({flush, stall, issue} !== 3'b100) begin errors++; $display("FAIL flush_hazard got=%b exp=100", {flush, stall, issue}); end
    tick();
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL flush_stall_count got=%0d exp=0", stall_count); end
    set_inst(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);       // HLT on wrong path
    ex_taken = 1'b1;
    @(negedge clk);
    checks++; if ({flush, issue} !== 2'b10) begin errors++; $display("FAIL flush_hlt got=%b exp=10", {flush, issue}); end
    tick();
    idle();
    for (int k = 0; k < 6; k++) tick();
    @(negedge clk);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL flush_no_halt got=%b exp=0", halted); end
    set_inst(5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);       // R1 retired, not pending
    @(negedge clk);
    checks++; if ({issue, stall, flush} !== 3'b100) begin errors++; $display("FAIL flush_resume got=%b exp=100", {issue, stall, flush}); end
    idle();
    tick();
  endtask

  // Repeated LW R1 ; ADD R4,R1,R1 pairs until the 4-bit counter pins at 15.
  task automatic test_saturation();
    int per;
    int total;
    per   = FWD ? 1 : DEPTH;
    total = 0;
    do_reset();
    for (int r = 0; r < 18; r++) begin
      set_inst(5'd0, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0);
      tick();
      set_inst(5'd1, 5'd1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall_r%0d_c%0d got=%b exp=1", r, c, stall); end
        tick();
      end
      tick();
      total = total + per;
      if (r == 3) begin
        checks++; if (stall_count !== 4'(total)) begin errors++; $display("FAIL sat_mid_count got=%0d exp=%0d", stall_count, total); end
      end
    end
    idle();
    @(negedge clk);
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat_final_count got=%0d exp=15", stall_count); end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_r0();
    test_halt();
    test_flush();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips32_issue_scheduler.md
Name: mips32_issue_scheduler

Overview:
- Single-clock issue controller for the pipelined MIPS32 datapath. Sits between the ID stage and EX.
- Tracks in-flight register writes in a shift-register scoreboard. Stalls ID on RAW hazards and flushes ID on taken branches.
- Sequences HLT drain to a sticky halted flag.
- Replaces software-inserted dummy OR instructions between dependent instructions.

Parameters:
- DEPTH, 3, in-flight stages tracked after ID (entry 0 = EX, DEPTH-1 = WB).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active high
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  5  source register 1
- id_rt  in  5  source register 2
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_dst  in  5  destination register
- id_wr  in  1  instruction writes id_dst
- id_load  in  1  instruction is LW
- id_halt  in  1  instruction is HLT
- ex_taken  in  1  branch in EX resolved taken this cycle
- issue  out  1  ID instruction advances to EX this cycle
- stall  out  1  ID instruction held this cycle; bubble into EX
- flush  out  1  ID (and IF) contents discarded this cycle
- halted  out  1  HLT issued and pipeline fully drained; sticky
- stall_count  out  CNT_W  number of cycles with stall=1

Behaviour:
- Interface: one clock (clk); reset synchronous, active high (rst).
- Reset values: halted=0, stall_count=0, halt_pending=0, all scoreboard entries invalid. issue, stall and flush follow from that state and the inputs.
- Scoreboard entry fields: occ (entry holds an instruction), wv (write valid), dst[4:0], ld.
- Every cycle the scoreboard shifts: sb[i+1]<=sb[i]; sb[DEPTH-1] retires.
  - If issue=1: sb[0] <= {occ=1, wv=id_wr&(id_dst!=0), dst=id_dst, ld=id_load}.
  - Otherwise sb[0] <= empty bubble.
- R0 never hazards: wv is forced 0 when dst=0, and sources equal to 0 never match.
- Hazard (combinational), without forwarding: any entry i in 0..DEPTH-1 with wv=1 and dst equal to a used nonzero source (id_use_rs & id_rs, or id_use_rt & id_rt).
  - The register file has no write-to-read bypass, so the WB entry also hazards.
- flush = ex_taken.
- issue = id_valid & ~hazard & ~halt_pending & ~ex_taken.
- stall = id_valid & hazard & ~halt_pending & ~ex_taken.
- issue and stall are never both 1. Flush wins over hazard and over issue in the same cycle. A flushed HLT does not set halt_pending.
- Halt sequencing:
  - issue with id_halt=1 sets halt_pending. No further issue until reset; issue=stall=0 while pending.
  - halted <= 1 on the first clock where halt_pending=1 and every entry has occ=0. The HLT entry itself must retire first.
  - Latency from HLT issue to halted=1 is DEPTH+1 cycles.
- stall_count increments on each cycle with stall=1 and saturates at all-ones (no wrap).
- Reset mid-operation (including during drain or while halted) clears all state on the next edge. Inputs in the reset cycle are ignored.
- ex_taken while the scoreboard holds writers: entries still retire normally. Only ID is flushed; the branch resolves in EX, so older entries are architecturally valid.

Optional Feature:
- Macro: MIPS32_FWD_EN.
- Defined: the datapath forwards EX/MEM/WB results. Hazard is restricted to the load-use case only: sb[0].wv & sb[0].ld & dst matches a used source.
  - This gives exactly one stall cycle per load-use pair. ALU-to-ALU dependencies never stall.
- Undefined: full interlock as described in Behaviour.

Test Plan:
- ADDI R1,R0,10 then ADD R4,R1,R2 back-to-back, no forwarding: stall=1 for 3 cycles (DEPTH), then issue=1; stall_count=3.
- Same pair with MIPS32_FWD_EN defined: no stall; the ADD issues the cycle after the ADDI; stall_count=0.
- LW R2,0(R1) then ADD R3,R2,R2 with MIPS32_FWD_EN: exactly 1 stall cycle, then issue.
- ADDI R0,R0,5 then ADD R4,R0,R0: never stalls (R0 exempt).
- HLT issued with 2 writers in flight: issue=0 afterwards, even with id_valid=1. halted rises 4 cycles after HLT issue (DEPTH=3) and stays 1. Asserting rst then clears halted, stall_count and scoreboard.
- ex_taken=1 in the same cycle as a hazarded id_valid: flush=1, stall=0, issue=0, stall_count unchanged. A HLT presented in that cycle is flushed and does not set halted.
